nco_pipe: RTL

Parametrised, pipelined numerically controlled oscillator for the NCO datapath. It accumulates a frequency control word, adds a programmable phase offset, and maps the phase to cosine or sine through a quadrant-folded, rotation-mode CORDIC pipeline. Output can be two's complement or offset binary. It succeeds the fixed 20-bit/12-bit `nco` and adds width parameters, a phase-offset input, a reset and a configurable CORDIC depth.

---
 rtl/nco_pipe.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/nco_pipe.sv
// nco_pipe: phase accumulator + phase offset + quadrant-folded CORDIC NCO.
// Latency ITER+2 from En to Vld; Dout holds while Vld=0.
// Ports: clk, rst (async, active high), En (advance/valid), FCW (freq word),
// PhOff (phase offset), selXY (1=cos,0=sin), selSign (1=2's comp,0=offset),
// Vld (sample valid), Dout (sample).
// Option macro NCO_PIPE_DITHER_EN: LFSR dither ahead of phase truncation.
module nco_pipe #(
  parameter int FCW_W = 20,
  parameter int PH_W  = 16,
  parameter int OUT_W = 12,
  parameter int ITER  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic [FCW_W-1:0] FCW,
  input  logic [PH_W-1:0]  PhOff,
  input  logic             selXY,
  input  logic             selSign,
  output logic             Vld,
  output logic [OUT_W-1:0] Dout
);

  localparam int IW  = OUT_W + 2;
  localparam int LAT = ITER + 2;

  // CORDIC start value pre-scaled by 1/K so the output peaks at full scale
  localparam longint X0L =
    (64'sd607253 * ((64'sd1 <<< (OUT_W - 1)) - 64'sd1)
     + 64'sd500000) / 64'sd1000000;
  localparam logic [IW-1:0] X0   = IW'(X0L);
  localparam logic [IW-1:0] MAXP =
    IW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic [IW-1:0] MAXN =
    IW'(64'sd1 - (64'sd1 <<< (OUT_W - 1)));

  // atan(2^-i) with 2^32 = full turn
  function automatic logic [31:0] atan32(input int i);
    case (i)
      0:       return 32'h20000000;
      1:       return 32'h12E4051E;
      2:       return 32'h09FB385B;
      3:       return 32'h051111D4;
      4:       return 32'h028B0D43;
      5:       return 32'h0145D7E1;
      6:       return 32'h00A2F61E;
      7:       return 32'h00517C55;
      8:       return 32'h0028BE53;
      9:       return 32'h00145F2F;
      10:      return 32'h000A2F98;
      11:      return 32'h000517CC;
      12:      return 32'h00028BE6;
      13:      return 32'h000145F3;
      14:      return 32'h0000A2FA;
      15:      return 32'h0000517D;
      default: return 32'(64'd683565276 >> i);
    endcase
  endfunction

  // same angle rounded to the PH_W phase scale
  function automatic logic [PH_W-1:0] atan_ph(input int i);
    logic [63:0] t;
    t = 64'(atan32(i));
    t = (t + (64'd1 << (31 - PH_W))) >> (32 - PH_W);
    return PH_W'(t);
  endfunction

  // rounded arithmetic shift keeps the truncation error zero-mean
  function automatic logic [IW-1:0] shr(
    input logic [IW-1:0] v,
    input int            s
  );
    logic signed [IW-1:0] r;
    r = $signed(v) + $signed(IW'((1 << s) >> 1));
    return r >>> s;
  endfunction

  function automatic logic [OUT_W-1:0] sat(input logic [IW-1:0] v);
    if ($signed(v) > $signed(MAXP))
      return OUT_W'(MAXP);
    else if ($signed(v) < $signed(MAXN))
      return OUT_W'(MAXN);
    else
      return OUT_W'(v);
  endfunction

  logic [FCW_W-1:0]          acc;
  logic [FCW_W-1:0]          acc_d;
  logic [PH_W-1:0]           ph;
  logic [ITER:0][IW-1:0]     xr;
  logic [ITER:0][IW-1:0]     yr;
  logic [ITER-1:0][PH_W-1:0] zr;
  logic [ITER:0][1:0]        qr;
  logic [ITER:0]             sxr;
  logic [ITER:0]             ssr;
  logic [LAT-1:0]            vp;
  logic [IW-1:0]             c;
  logic [IW-1:0]             s;
  logic [IW-1:0]             pick;
  logic [OUT_W-1:0]          res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (En)
      acc <= acc + FCW;
  end

`ifdef NCO_PIPE_DITHER_EN
  localparam int DW = FCW_W - PH_W;
  localparam logic [FCW_W-1:0] DMASK =
    FCW_W'((64'd1 << DW) - 64'd1);

  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr <= 16'hACE1;
    else if (En)
      lfsr <= {lfsr[14:0],
               lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign acc_d = acc + (FCW_W'(lfsr) & DMASK);
`else
  assign acc_d = acc;
`endif

  assign ph = PH_W'(acc_d >> (FCW_W - PH_W)) + PhOff;

  // index 0 is the phase stage, k+1 is CORDIC stage k
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr  <= '0;
      yr  <= '0;
      zr  <= '0;
      qr  <= '0;
      sxr <= '0;
      ssr <= '0;
    end else begin
      xr[0]  <= X0;
      yr[0]  <= '0;
      zr[0]  <= {2'b00, ph[PH_W-3:0]};
      qr[0]  <= ph[PH_W-1 -: 2];
      sxr[0] <= selXY;
      ssr[0] <= selSign;
      for (int k = 0; k < ITER; k++) begin
        if (zr[k][PH_W-1]) begin
          xr[k+1] <= xr[k] + shr(yr[k], k);
          yr[k+1] <= yr[k] - shr(xr[k], k);
        end else begin
          xr[k+1] <= xr[k] - shr(yr[k], k);
          yr[k+1] <= yr[k] + shr(xr[k], k);
        end
        qr[k+1]  <= qr[k];
        sxr[k+1] <= sxr[k];
        ssr[k+1] <= ssr[k];
      end
      for (int k = 0; k < ITER - 1; k++) begin
        zr[k+1] <= zr[k][PH_W-1] ? zr[k] + atan_ph(k)
                                 : zr[k] - atan_ph(k);
      end
    end
  end

  // quadrant restore, saturate, select, format
  always_comb begin
    c = xr[ITER];
    s = yr[ITER];
    case (qr[ITER])
      2'd1: begin
        c = -yr[ITER];
        s = xr[ITER];
      end
      2'd2: begin
        c = -xr[ITER];
        s = -yr[ITER];
      end
      2'd3: begin
        c = yr[ITER];
        s = -xr[ITER];
      end
      default: ;
    endcase
    pick = sxr[ITER] ? c : s;
    res  = sat(pick);
    if (!ssr[ITER])
      res[OUT_W-1] = ~res[OUT_W-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vp   <= '0;
      Dout <= '0;
    end else begin
      vp <= {vp[LAT-2:0], En};
      if (vp[LAT-2])
        Dout <= res;
    end
  end

  assign Vld = vp[LAT-1];

endmodule
